mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl.sv | 100 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential WIDTH x WIDTH multiplier controller driving a shared 2x2-bit multiplier digit by digit.
// Optional macro MULT_SEQ_ZERO_SKIP_EN: zero operands bypass RUN and go straight to DONE.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [1:0]         mul_a,
  output logic [1:0]         mul_b,
  input  logic [3:0]         mul_p
);

  localparam int unsigned D  = WIDTH / 2;
  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d;
  logic [IW:0]      dsum_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // Digit weight exponent: partial product lands at 4^(i+j)
  assign dsum_c = (IW+1)'(i_q) + (IW+1)'(j_q);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
`ifdef MULT_SEQ_ZERO_SKIP_EN
          if ((in_a == '0) || (in_b == '0)) state_d = DONE;
`endif
        end
      end
      RUN: begin
        acc_d = acc_q + (PW'(mul_p) << {dsum_c, 1'b0});
        if (j_q == IW'(D - 1)) begin
          j_d = '0;
          if (i_q == IW'(D - 1)) state_d = DONE;
          else i_d = i_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode directly from registered state; digits are zero outside RUN
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_p     = acc_q;
  assign mul_a     = (state_q == RUN) ? 2'(a_q >> {i_q, 1'b0}) : 2'b00;
  assign mul_b     = (state_q == RUN) ? 2'(b_q >> {j_q, 1'b0}) : 2'b00;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed and table-driven bench for mult_seq_ctrl (WIDTH=8) with a behavioural 2x2 multiplier.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [15:0] out_p;
  logic [1:0]  mul_a, mul_b;
  logic [3:0]  mul_p;

  int errors = 0;
  int checks = 0;

  mult_seq_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  assign mul_p = 4'(mul_a) * 4'(mul_b);

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          hold;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_SEQ_ZERO_SKIP_EN
    return ((a == 8'h00) || (b == 8'h00)) ? 1 : 17;
`else
    return 17;
`endif
  endfunction

  // Digits must be idle whenever the controller is not running
  always @(negedge clk) begin
    if (!rst && (in_ready || out_valid)) begin
      chk("mul_idle_zero", 32'({mul_a, mul_b}), 32'h0);
      chk("ready_valid_excl", 32'(in_ready & out_valid), 32'h0);
    end
  end

  // Offer one operand pair, wait for the product, stall 'hold' cycles, then take it
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                       input logic [15:0] exp_p, input int lat);
    int n;
    int cyc;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", 32'(in_ready), 32'h1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'h0, 32'h1);
      return;
    end
    if (lat > 0) chk("latency", 32'(cyc), 32'(lat));
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_p", 32'(out_p), 32'(exp_p));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("product", 32'(out_p), 32'(exp_p));
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("one_cycle_valid", 32'(out_valid), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] adig [4];
    logic [7:0] bdig [4];
    int n;

    vecs[0] = '{8'hFF, 8'hFF, 0, 16'hFE01};
    vecs[1] = '{8'hE4, 8'h01, 0, 16'h00E4};
    vecs[2] = '{8'h00, 8'h37, 0, 16'h0000};
    vecs[3] = '{8'h0D, 8'h0B, 2, 16'h008F};
    vecs[4] = '{8'h01, 8'h01, 0, 16'h0001};
    vecs[5] = '{8'h80, 8'h02, 1, 16'h0100};
    vecs[6] = '{8'hAA, 8'h55, 0, 16'h3872};
    vecs[7] = '{8'hFF, 8'h00, 0, 16'h0000};
    vecs[8] = '{8'h0F, 8'hF0, 3, 16'h0E10};
    vecs[9] = '{8'h12, 8'h34, 0, 16'h03A8};

    rst = 1'b1; in_valid = 1'b0; in_a = 8'h0; in_b = 8'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_p", 32'(out_p), 32'h0);
    chk("rst_mul", 32'({mul_a, mul_b}), 32'h0);
    rst = 1'b0;

    foreach (vecs[k]) do_op(vecs[k].a, vecs[k].b, vecs[k].hold, vecs[k].p, exp_lat(vecs[k].a, vecs[k].b));

    // Digit sequencing: i outer, j inner
    adig = '{8'd0, 8'd1, 8'd2, 8'd3};
    bdig = '{8'd1, 8'd0, 8'd0, 8'd0};
    in_valid = 1'b1; in_a = 8'hE4; in_b = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("seq_mul_a", 32'(mul_a), 32'(adig[k / 4]));
      chk("seq_mul_b", 32'(mul_b), 32'(bdig[k % 4]));
      @(posedge clk); #1;
    end
    chk("seq_valid", 32'(out_valid), 32'h1);
    chk("seq_p", 32'(out_p), 32'h00E4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Stall in DONE with new operands offered; they must be ignored
    in_valid = 1'b1; in_a = 8'h0D; in_b = 8'h0B;
    @(posedge clk); #1;
    in_a = 8'hFF; in_b = 8'hFF;
    n = 1;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("stall_latency", 32'(n), 32'd17);
    for (int k = 0; k < 5; k++) begin
      chk("stall_p", 32'(out_p), 32'h008F);
      chk("stall_in_ready", 32'(in_ready), 32'h0);
      chk("stall_valid", 32'(out_valid), 32'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("stall_final_p", 32'(out_p), 32'h008F);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("stall_back_idle", 32'(in_ready), 32'h1);
    chk("stall_valid_drop", 32'(out_valid), 32'h0);

    // Reset during the 7th RUN cycle abandons the operation
    in_valid = 1'b1; in_a = 8'h77; in_b = 8'h99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    chk("rrun_in_ready", 32'(in_ready), 32'h1);
    chk("rrun_out_valid", 32'(out_valid), 32'h0);
    chk("rrun_mul", 32'({mul_a, mul_b}), 32'h0);
    chk("rrun_out_p", 32'(out_p), 32'h0);
    do_op(8'h03, 8'h05, 0, 16'h000F, 17);

    // Grid plus random operands, back to back with random consumer stalls
    for (int a = 0; a < 256; a += 17)
      for (int b = 0; b < 256; b += 5)
        do_op(8'(a), 8'(b), int'($urandom_range(0, 2)), 16'(a) * 16'(b), 0);
    for (int k = 0; k < 500; k++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ra, rb, int'($urandom_range(0, 2)), 16'(ra) * 16'(rb), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
